// File: rtl/cgra_bram_pkg.sv
// Shared definitions for the CGRA BRAM port responder: default widths,
// address LSB, access classification, lane-mask helper and latency legality.
package cgra_bram_pkg;

    localparam int unsigned SYS_DWIDTH   = 32;
    localparam int unsigned BYTE_LEN     = 4;
    localparam int unsigned ADDR_LSB     = 2;
    localparam int unsigned READ_LAT_MIN = 1;
    localparam int unsigned READ_LAT_MAX = 2;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_kind_e;

    function automatic logic [SYS_DWIDTH-1:0] wen_to_mask(input logic [BYTE_LEN-1:0] wen);
        logic [SYS_DWIDTH-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < BYTE_LEN; i++) begin
            m[8*i +: 8] = {8{wen[i]}};
        end
        return m;
    endfunction

    function automatic bit read_lat_legal(input int unsigned lat);
        return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
    endfunction

endpackage

// File: rtl/bram_port_responder_if.sv
// BRAM port bundle: the CGRA initiator is the master, the memory responder the slave.
interface bram_port_responder_if #(
    parameter int unsigned SYS_DWIDTH = 32,
    parameter int unsigned BYTE_LEN   = 4
);

    logic                  Port_Rst;
    logic                  Port_En;
    logic [BYTE_LEN-1:0]   Port_Wen;
    logic [SYS_DWIDTH-1:0] Port_Addr;
    logic [SYS_DWIDTH-1:0] Port_Data_To_Bram;
    logic [SYS_DWIDTH-1:0] Port_Data_From_Bram;
    logic                  Rd_Valid;

    modport master (
        output Port_Rst, Port_En, Port_Wen, Port_Addr, Port_Data_To_Bram,
        input  Port_Data_From_Bram, Rd_Valid
    );

    modport slave (
        input  Port_Rst, Port_En, Port_Wen, Port_Addr, Port_Data_To_Bram,
        output Port_Data_From_Bram, Rd_Valid
    );

endinterface

// File: rtl/bram_rd_pipe.sv
// Read-data output pipeline (READ_LAT 1 or 2) carrying data, load and valid,
// with a synchronous Port_Rst clear of every stage.
module bram_rd_pipe #(
    parameter int unsigned DW       = 32,
    parameter int unsigned READ_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          port_rst_i,
    input  logic          ld_i,
    input  logic          vld_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic          vld_o
);

    logic [DW-1:0] out_q, out_d;
    logic          vld_q, vld_d;
    logic [DW-1:0] src_data;
    logic          src_ld;
    logic          src_vld;

    if (READ_LAT == 2) begin : g_lat2
        logic [DW-1:0] stg_q, stg_d;
        logic          stg_ld_q, stg_ld_d;
        logic          stg_vld_q, stg_vld_d;

        always_comb begin
            stg_d     = stg_q;
            stg_ld_d  = ld_i & ~port_rst_i;
            stg_vld_d = vld_i & ~port_rst_i;
            if (port_rst_i) begin
                stg_d = '0;
            end else if (ld_i) begin
                stg_d = data_i;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                stg_q     <= '0;
                stg_ld_q  <= 1'b0;
                stg_vld_q <= 1'b0;
            end else begin
                stg_q     <= stg_d;
                stg_ld_q  <= stg_ld_d;
                stg_vld_q <= stg_vld_d;
            end
        end

        assign src_data = stg_q;
        assign src_ld   = stg_ld_q;
        assign src_vld  = stg_vld_q;
    end else begin : g_lat1
        assign src_data = data_i;
        assign src_ld   = ld_i;
        assign src_vld  = vld_i;
    end

    // Writes load the read-first word (src_ld) but never raise valid (src_vld).
    always_comb begin
        out_d = out_q;
        vld_d = 1'b0;
        if (port_rst_i) begin
            out_d = '0;
        end else begin
            if (src_ld) begin
                out_d = src_data;
            end
            vld_d = src_vld;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign data_o = out_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/bram_port_responder.sv
// Single-port BRAM responder for one CGRA port: byte-lane writes, read-first,
// range checking. Optional access counters via BRAM_ACCESS_CNT_EN.
module bram_port_responder #(
    parameter int unsigned SYS_DWIDTH = cgra_bram_pkg::SYS_DWIDTH,
    parameter int unsigned BYTE_LEN   = cgra_bram_pkg::BYTE_LEN,
    parameter int unsigned AW         = 10,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Err_Clr,
    output logic                  Range_Err,
    output logic [31:0]           Rd_Cnt,
    output logic [31:0]           Wr_Cnt,
    bram_port_responder_if.slave  port
);

    import cgra_bram_pkg::*;

    if (!read_lat_legal(READ_LAT)) begin : g_bad_read_lat
        $error("bram_port_responder: READ_LAT must be 1 or 2");
    end

    logic [SYS_DWIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         idx;
    logic                  in_range;
    acc_kind_e             acc;
    logic [SYS_DWIDTH-1:0] rd_word;
    logic [SYS_DWIDTH-1:0] wmask;
    logic                  range_err_q, range_err_d;

    always_comb begin
        idx      = port.Port_Addr[AW+ADDR_LSB-1:ADDR_LSB];
        in_range = (port.Port_Addr[SYS_DWIDTH-1:AW+ADDR_LSB] == '0) &&
                   ({1'b0, idx} < (AW+1)'(DEPTH));
        if (!port.Port_En) begin
            acc = ACC_NONE;
        end else if (|port.Port_Wen) begin
            acc = ACC_WRITE;
        end else begin
            acc = ACC_READ;
        end
        rd_word = in_range ? mem[idx] : '0;
        wmask   = wen_to_mask(port.Port_Wen);
    end

    // Array is deliberately unreset so it maps onto block RAM.
    always_ff @(posedge Clk) begin
        if (acc == ACC_WRITE && in_range) begin
            mem[idx] <= (mem[idx] & ~wmask) | (port.Port_Data_To_Bram & wmask);
        end
    end

    always_comb begin
        range_err_d = range_err_q;
        if (port.Port_En && !in_range) begin
            range_err_d = 1'b1;
        end else if (Err_Clr) begin
            range_err_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    assign Range_Err = range_err_q;

    bram_rd_pipe #(
        .DW       (SYS_DWIDTH),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .port_rst_i (port.Port_Rst),
        .ld_i       (acc != ACC_NONE),
        .vld_i      (acc == ACC_READ),
        .data_i     (rd_word),
        .data_o     (port.Port_Data_From_Bram),
        .vld_o      (port.Rd_Valid)
    );

`ifdef BRAM_ACCESS_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (Err_Clr) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end else begin
            if (acc == ACC_READ && rd_cnt_q != '1) begin
                rd_cnt_d = rd_cnt_q + 32'd1;
            end
            if (acc == ACC_WRITE && wr_cnt_q != '1) begin
                wr_cnt_d = wr_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign Rd_Cnt = rd_cnt_q;
    assign Wr_Cnt = wr_cnt_q;
`else
    assign Rd_Cnt = '0;
    assign Wr_Cnt = '0;
`endif

endmodule

// File: tb/tb_bram_port_responder.sv
// Directed bench for bram_port_responder: one instance at READ_LAT=1, one at READ_LAT=2.
module tb_bram_port_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        err_clr1, err_clr2;
    logic        range_err1, range_err2;
    logic [31:0] rdc1, wrc1, rdc2, wrc2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bram_port_responder_if #(.SYS_DWIDTH(32), .BYTE_LEN(4)) p1 ();
    bram_port_responder_if #(.SYS_DWIDTH(32), .BYTE_LEN(4)) p2 ();

    bram_port_responder #(
        .SYS_DWIDTH(32), .BYTE_LEN(4), .AW(10), .DEPTH(1024), .READ_LAT(1)
    ) u_dut1 (
        .Clk(clk), .Rst(rst), .Err_Clr(err_clr1), .Range_Err(range_err1),
        .Rd_Cnt(rdc1), .Wr_Cnt(wrc1), .port(p1)
    );

    bram_port_responder #(
        .SYS_DWIDTH(32), .BYTE_LEN(4), .AW(10), .DEPTH(1024), .READ_LAT(2)
    ) u_dut2 (
        .Clk(clk), .Rst(rst), .Err_Clr(err_clr2), .Range_Err(range_err2),
        .Rd_Cnt(rdc2), .Wr_Cnt(wrc2), .port(p2)
    );

`ifdef BRAM_ACCESS_CNT_EN
    localparam logic [31:0] EXP_RD = 32'd5;
    localparam logic [31:0] EXP_WR = 32'd3;
`else
    localparam logic [31:0] EXP_RD = 32'd0;
    localparam logic [31:0] EXP_WR = 32'd0;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one access on a port, then advance to 1 time unit past the next edge.
    task automatic cyc1(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] data, input logic prst);
        p1.Port_En = en; p1.Port_Wen = wen; p1.Port_Addr = addr;
        p1.Port_Data_To_Bram = data; p1.Port_Rst = prst;
        @(posedge clk); #1;
    endtask

    task automatic cyc2(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] data, input logic prst);
        p2.Port_En = en; p2.Port_Wen = wen; p2.Port_Addr = addr;
        p2.Port_Data_To_Bram = data; p2.Port_Rst = prst;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; err_clr1 = 1'b0; err_clr2 = 1'b0;
        p1.Port_En = 0; p1.Port_Wen = '0; p1.Port_Addr = '0; p1.Port_Data_To_Bram = '0; p1.Port_Rst = 0;
        p2.Port_En = 0; p2.Port_Wen = '0; p2.Port_Addr = '0; p2.Port_Data_To_Bram = '0; p2.Port_Rst = 0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_data1", p1.Port_Data_From_Bram, 32'h0);
        check_val("rst_valid1", {31'b0, p1.Rd_Valid}, 32'h0);
        check_val("rst_rerr1", {31'b0, range_err1}, 32'h0);
        check_val("rst_data2", p2.Port_Data_From_Bram, 32'h0);
        check_val("rst_valid2", {31'b0, p2.Rd_Valid}, 32'h0);
        check_val("rst_rdcnt", rdc1, 32'h0);
        check_val("rst_wrcnt", wrc1, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic write/read, latency 1
        cyc1(1, 4'hF, 32'h10, 32'hDEADBEEF, 0);
        check_val("wr_no_valid", {31'b0, p1.Rd_Valid}, 32'h0);
        cyc1(1, 4'h0, 32'h10, 32'h0, 0);
        check_val("rd_data", p1.Port_Data_From_Bram, 32'hDEADBEEF);
        check_val("rd_valid", {31'b0, p1.Rd_Valid}, 32'h1);
        cyc1(0, 4'h0, 32'h0, 32'h0, 0);
        check_val("hold_data", p1.Port_Data_From_Bram, 32'hDEADBEEF);
        check_val("hold_valid", {31'b0, p1.Rd_Valid}, 32'h0);

        // Byte lanes with read-first
        cyc1(1, 4'hF, 32'h20, 32'h11223344, 0);
        cyc1(1, 4'b0101, 32'h20, 32'hAABBCCDD, 0);
        check_val("rdfirst_data", p1.Port_Data_From_Bram, 32'h11223344);
        check_val("rdfirst_valid", {31'b0, p1.Rd_Valid}, 32'h0);
        cyc1(1, 4'h0, 32'h20, 32'h0, 0);
        check_val("lane_data", p1.Port_Data_From_Bram, 32'h11BB33DD);

        // Range error
        cyc1(1, 4'h0, 32'h1000, 32'h0, 0);
        check_val("oor_data", p1.Port_Data_From_Bram, 32'h0);
        check_val("oor_valid", {31'b0, p1.Rd_Valid}, 32'h1);
        check_val("oor_rerr", {31'b0, range_err1}, 32'h1);
        err_clr1 = 1'b1;
        cyc1(1, 4'h0, 32'h2000, 32'h0, 0);
        check_val("set_over_clr", {31'b0, range_err1}, 32'h1);
        cyc1(0, 4'h0, 32'h0, 32'h0, 0);
        check_val("clr_rerr", {31'b0, range_err1}, 32'h0);
        err_clr1 = 1'b0;
        cyc1(1, 4'hF, 32'h1010, 32'h12345678, 0);
        check_val("oor_wr_rerr", {31'b0, range_err1}, 32'h1);
        err_clr1 = 1'b1;
        cyc1(0, 4'h0, 32'h0, 32'h0, 0);
        err_clr1 = 1'b0;
        cyc1(1, 4'h0, 32'h10, 32'h0, 0);
        check_val("oor_wr_nochg", p1.Port_Data_From_Bram, 32'hDEADBEEF);

        // Port_Rst on a completing read; write in the same cycle still commits
        cyc1(1, 4'h0, 32'h10, 32'h0, 1);
        check_val("prst_data", p1.Port_Data_From_Bram, 32'h0);
        check_val("prst_valid", {31'b0, p1.Rd_Valid}, 32'h0);
        cyc1(1, 4'hF, 32'h30, 32'hCAFEF00D, 1);
        cyc1(1, 4'h0, 32'h30, 32'h0, 0);
        check_val("prst_wr_commit", p1.Port_Data_From_Bram, 32'hCAFEF00D);

        // Access counters: 5 reads, 3 writes
        err_clr1 = 1'b1;
        cyc1(0, 4'h0, 32'h0, 32'h0, 0);
        err_clr1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc1(1, 4'h0, 32'h10, 32'h0, 0);
            if (i < 3) cyc1(1, 4'h3, 32'h40, 32'h0, 0);
        end
        check_val("rd_cnt", rdc1, EXP_RD);
        check_val("wr_cnt", wrc1, EXP_WR);
        err_clr1 = 1'b1;
        cyc1(0, 4'h0, 32'h0, 32'h0, 0);
        err_clr1 = 1'b0;
        check_val("rd_cnt_clr", rdc1, 32'h0);
        check_val("wr_cnt_clr", wrc1, 32'h0);

        // Latency-2 pipelining
        cyc2(1, 4'hF, 32'h0, 32'd1, 0);
        cyc2(1, 4'hF, 32'h4, 32'd2, 0);
        cyc2(1, 4'hF, 32'h8, 32'd3, 0);
        cyc2(1, 4'h0, 32'h0, 32'h0, 0);
        check_val("pipe_v0", {31'b0, p2.Rd_Valid}, 32'h0);
        cyc2(1, 4'h0, 32'h4, 32'h0, 0);
        check_val("pipe_d1", p2.Port_Data_From_Bram, 32'd1);
        check_val("pipe_v1", {31'b0, p2.Rd_Valid}, 32'h1);
        cyc2(1, 4'h0, 32'h8, 32'h0, 0);
        check_val("pipe_d2", p2.Port_Data_From_Bram, 32'd2);
        check_val("pipe_v2", {31'b0, p2.Rd_Valid}, 32'h1);
        cyc2(0, 4'h0, 32'h0, 32'h0, 0);
        check_val("pipe_d3", p2.Port_Data_From_Bram, 32'd3);
        check_val("pipe_v3", {31'b0, p2.Rd_Valid}, 32'h1);
        cyc2(0, 4'h0, 32'h0, 32'h0, 0);
        check_val("pipe_hold_d", p2.Port_Data_From_Bram, 32'd3);
        check_val("pipe_hold_v", {31'b0, p2.Rd_Valid}, 32'h0);

        // Port_Rst clears the latency-2 internal stage
        cyc2(1, 4'h0, 32'h4, 32'h0, 0);
        cyc2(0, 4'h0, 32'h0, 32'h0, 1);
        check_val("prst2_data", p2.Port_Data_From_Bram, 32'h0);
        check_val("prst2_valid", {31'b0, p2.Rd_Valid}, 32'h0);
        cyc2(0, 4'h0, 32'h0, 32'h0, 0);
        check_val("prst2_stage_d", p2.Port_Data_From_Bram, 32'h0);
        check_val("prst2_stage_v", {31'b0, p2.Rd_Valid}, 32'h0);

        // Async reset between issue and completion
        cyc2(1, 4'h0, 32'h4, 32'h0, 0);
        p2.Port_En = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_val("arst_data", p2.Port_Data_From_Bram, 32'h0);
        check_val("arst_valid", {31'b0, p2.Rd_Valid}, 32'h0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_val("arst_no_valid", {31'b0, p2.Rd_Valid}, 32'h0);
        cyc2(1, 4'h0, 32'h8, 32'h0, 0);
        cyc2(0, 4'h0, 32'h0, 32'h0, 0);
        check_val("arst_mem_d", p2.Port_Data_From_Bram, 32'd3);
        check_val("arst_mem_v", {31'b0, p2.Rd_Valid}, 32'h1);
        cyc1(1, 4'h0, 32'h20, 32'h0, 0);
        check_val("arst_mem1", p1.Port_Data_From_Bram, 32'h11BB33DD);
        cyc1(0, 4'h0, 32'h0, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_port_responder.md
Name: bram_port_responder

Overview:
- Memory-side responder for one CGRA BRAM port.
- The CGRA's BRAM interface is the initiator. It drives clock, reset, enable, byte write enables, byte address and write data on the port. This block answers with read data, behaving as a single-port block RAM.
- Used as the on-chip data/address-control memory behind one port, and as the reference memory model in CGRA benches.

Parameters:
- SYS_DWIDTH, 32, port data/address width in bits.
- BYTE_LEN, 4, number of byte lanes; SYS_DWIDTH = 8*BYTE_LEN.
- AW, 10, word-index width.
- DEPTH, 1024, number of words; DEPTH <= 2**AW.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.

Ports:
- Clk  in  1  port clock, driven from the initiator's Port_Clk.
- Rst  in  1  asynchronous active-high reset.
- Port_Rst  in  1  synchronous output-register clear, active high.
- Port_En  in  1  access enable.
- Port_Wen  in  BYTE_LEN  byte write enables.
- Port_Addr  in  SYS_DWIDTH  byte address.
- Port_Data_To_Bram  in  SYS_DWIDTH  write data.
- Port_Data_From_Bram  out  SYS_DWIDTH  read data.
- Rd_Valid  out  1  one-cycle pulse; Port_Data_From_Bram holds new read data this cycle.
- Range_Err  out  1  sticky flag; an out-of-range access has occurred.
- Err_Clr  in  1  synchronous clear of Range_Err.
- Rd_Cnt  out  32  read-access count (optional feature).
- Wr_Cnt  out  32  write-access count (optional feature).

Behaviour:
- One clock (Clk). Reset Rst is asynchronous, active-high.
- Reset values:
  - Port_Data_From_Bram=0, Rd_Valid=0, Range_Err=0, Rd_Cnt=0, Wr_Cnt=0.
  - Read pipeline is flushed.
  - Memory array is NOT reset.
- Address decode:
  - idx = Port_Addr[AW+1:2]; bits [1:0] are ignored.
  - In range iff Port_Addr[SYS_DWIDTH-1:AW+2]==0 and idx<DEPTH.
- Access classification when Port_En=1:
  - Write: |Port_Wen = 1.
  - Read: Port_Wen = 0.
  - Port_En=0: no access, all Wen ignored.
- Write (in range):
  - Each lane i with Port_Wen[i] updates mem[idx][8i+7:8i] at the clock edge.
  - Other lanes are untouched.
  - A write also performs a read-first read of the old word. Port_Data_From_Bram updates, but Rd_Valid does not pulse.
- Read (in range), READ_LAT=1:
  - Access at edge N: mem[idx] appears on Port_Data_From_Bram after edge N.
  - Rd_Valid=1 for the cycle after edge N.
- Read, READ_LAT=2:
  - Data is captured into an internal stage at edge N and moved to the output at edge N+1.
  - Rd_Valid is high for the cycle after edge N+1.
  - Back-to-back reads are fully pipelined: one per cycle, no bubbles.
- Output hold: with no new read completing, Port_Data_From_Bram holds its last value and Rd_Valid=0.
- Out-of-range access (read or write):
  - Memory is unchanged.
  - A read returns 0 with normal latency and Rd_Valid.
  - Range_Err is set at the same edge.
- Range_Err precedence:
  - Err_Clr clears it.
  - Set wins over clear when both occur in the same cycle.
- Port_Rst=1:
  - Output register cleared to 0 at the edge; this has priority over a completing read.
  - Rd_Valid is suppressed for that edge.
  - The internal READ_LAT=2 stage is also cleared.
  - Writes in the same cycle still commit.
- Async Rst mid-read: the in-flight read is dropped; no Rd_Valid follows.
- READ_LAT outside {1,2}: elaboration error via a generate-time check.

Optional Feature:
- Macro: BRAM_ACCESS_CNT_EN.
- Defined:
  - Rd_Cnt increments on each accepted read (Port_En & ~|Port_Wen).
  - Wr_Cnt increments on each accepted write (Port_En & |Port_Wen).
  - Out-of-range accesses are included in the counts.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both are cleared by Rst and by Err_Clr.
- Undefined: Rd_Cnt and Wr_Cnt tied to 0; no counter logic is synthesised.

Decomposition:
- Shared package cgra_bram_pkg holds:
  - SYS_DWIDTH/BYTE_LEN defaults;
  - the ADDR_LSB=2 constant;
  - a byte-lane mask function (Wen to bit mask);
  - the latency-legal check constant.
- One sub-module, bram_rd_pipe: parameterised READ_LAT output pipeline carrying data and valid, with Port_Rst clear.
- Memory array and decode stay in the top.

Test Plan:
- Basic write/read, READ_LAT=1: write 32'hDEADBEEF to addr 0x10 with Wen=4'hF, then read 0x10 → 32'hDEADBEEF one cycle later, Rd_Valid pulses once.
- Byte lanes:
  - Preload 0x11223344 at addr 0x20.
  - Write 0xAABBCCDD with Wen=4'b0101.
  - Read 0x20 → 0x11BB33DD.
- Pipelining, READ_LAT=2: reads of addrs 0x0, 0x4, 0x8 on consecutive cycles, holding 1, 2, 3 → outputs 1, 2, 3 on consecutive cycles starting two cycles after the first; three Rd_Valid pulses.
- Range error:
  - Read 0x1000 with DEPTH=1024 → data 0, Range_Err=1.
  - Same-cycle Err_Clr plus another bad access → Range_Err stays 1.
  - Err_Clr alone → Range_Err=0.
- Port_Rst and async reset:
  - Port_Rst during a completing read → output 0, no Rd_Valid.
  - Rst asserted between issue and completion with READ_LAT=2 → no Rd_Valid; memory contents preserved on a later readback.
- BRAM_ACCESS_CNT_EN: 5 reads and 3 writes → Rd_Cnt=5, Wr_Cnt=3; Err_Clr → both 0.
